// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the EX->MEM pipeline stage.
// Build option PIPE_STAGE_FWD_EN is consumed by pipe_stage_ex_mem.
package pipeline_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 7;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   data;
        logic [REG_AW-1:0] rd;
        logic [OP_W-1:0]   opcode;
    } ex_mem_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} stage_state_t;

    // The stage state is fully encoded by the two slot valid bits.
    function automatic stage_state_t state_of(input logic out_vld, input logic skid_vld);
        if (skid_vld) return FULL;
        if (out_vld)  return ONE;
        return EMPTY;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with load enable, valid bit and synchronous valid clear.
// Captures on the falling clock edge like the other pipeline registers.
module pipe_slot
    import pipeline_pkg::*;
#(
    parameter type T = ex_mem_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic clear_i,
    input  T     d_i,
    output logic valid_o,
    output T     q_o
);

    logic valid_q;
    T     payload_q;

    // Clear only drops the valid bit; payload is kept as don't-care.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            payload_q <= d_i;
        end else if (clear_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = payload_q;

endmodule

// File: rtl/pipe_stage_ex_mem.sv
// Two-entry elastic EX->MEM stage (output slot + skid slot) with flush and sync reset.
// Define PIPE_STAGE_FWD_EN to add the fwd_valid/fwd_rd/fwd_data forwarding outputs.
module pipe_stage_ex_mem #(
    parameter int unsigned XLEN   = pipeline_pkg::XLEN,
    parameter int unsigned REG_AW = pipeline_pkg::REG_AW,
    parameter int unsigned OP_W   = pipeline_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   result_in,
    input  logic [XLEN-1:0]   data_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [OP_W-1:0]   opcode_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result_out,
    output logic [XLEN-1:0]   data_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [OP_W-1:0]   opcode_out
`ifdef PIPE_STAGE_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data
`endif
);

    import pipeline_pkg::*;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   data;
        logic [REG_AW-1:0] rd;
        logic [OP_W-1:0]   opcode;
    } slot_t;

    slot_t        in_beat, out_q, skid_q, out_d;
    logic         skid_valid;
    logic         in_xfer, out_xfer;
    logic         out_load, out_clr, skid_load, skid_clr;
    stage_state_t state;

    assign in_beat  = '{result: result_in, data: data_in, rd: rd_in, opcode: opcode_in};
    assign in_ready = ~skid_valid & ~rst;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign state    = state_of(out_valid, skid_valid);

    always_comb begin
        out_load  = 1'b0;
        out_clr   = 1'b0;
        out_d     = in_beat;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            // Any beat offered alongside a flush is dropped.
            out_clr  = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                EMPTY: out_load = in_xfer;
                ONE: begin
                    if (out_xfer) begin
                        out_load = in_xfer;
                        out_clr  = ~in_xfer;
                    end else begin
                        skid_load = in_xfer;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        out_load = 1'b1;
                        out_d    = skid_q;
                        skid_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_slot #(.T(slot_t)) u_out_slot (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (out_load),
        .clear_i (out_clr),
        .d_i     (out_d),
        .valid_o (out_valid),
        .q_o     (out_q)
    );

    pipe_slot #(.T(slot_t)) u_skid_slot (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .d_i     (in_beat),
        .valid_o (skid_valid),
        .q_o     (skid_q)
    );

    assign result_out = out_q.result;
    assign data_out   = out_q.data;
    assign rd_out     = out_q.rd;
    assign opcode_out = out_q.opcode;

`ifdef PIPE_STAGE_FWD_EN
    assign fwd_valid = out_valid & (out_q.rd != '0);
    assign fwd_rd    = out_q.rd;
    assign fwd_data  = out_q.result;
`endif

endmodule

// File: tb/tb_pipe_stage_ex_mem.sv
// Self-checking bench for pipe_stage_ex_mem: directed steps plus random traffic
// checked against a two-deep FIFO reference model.
module tb_pipe_stage_ex_mem;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 7;
    localparam int PW     = 2 * XLEN + REG_AW + OP_W;

    typedef logic [PW-1:0] beat_t;  // {result, data, rd, opcode}

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0]   result_in, data_in, result_out, data_out;
    logic [REG_AW-1:0] rd_in, rd_out;
    logic [OP_W-1:0]   opcode_in, opcode_out;
`ifdef PIPE_STAGE_FWD_EN
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;
`endif

    pipe_stage_ex_mem dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result_in  (result_in),
        .data_in    (data_in),
        .rd_in      (rd_in),
        .opcode_in  (opcode_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .data_out   (data_out),
        .rd_out     (rd_out),
        .opcode_out (opcode_out)
`ifdef PIPE_STAGE_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t mq[$];
    beat_t last_out = '0;

    function automatic beat_t mk(input logic [XLEN-1:0] r, input logic [XLEN-1:0] d,
                                 input logic [REG_AW-1:0] rd, input logic [OP_W-1:0] op);
        return {r, d, rd, op};
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input beat_t b, input logic ordy);
        in_valid = v;
        {result_in, data_in, rd_in, opcode_in} = b;
        out_ready = ordy;
    endtask

    // One clock: check in_ready, advance the model across the falling edge, check outputs.
    task automatic cycle();
        logic  exp_ir, ixf, oxf, r, f;
        beat_t b;
        #1;
        exp_ir = (mq.size() < 2) && !rst;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        ixf = in_valid && exp_ir;
        oxf = (mq.size() > 0) && out_ready;
        r   = rst;
        f   = flush;
        b   = {result_in, data_in, rd_in, opcode_in};
        @(negedge clk);
        #1;
        if (r) begin
            mq.delete();
            last_out = '0;
        end else if (f) begin
            mq.delete();
        end else begin
            if (oxf) void'(mq.pop_front());
            if (ixf) mq.push_back(b);
            if (mq.size() > 0) last_out = mq[0];
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        check("result_out", result_out, last_out[PW-1 -: XLEN]);
        check("data_out", data_out, last_out[PW-XLEN-1 -: XLEN]);
        check("rd_out", {27'd0, rd_out}, {27'd0, last_out[OP_W +: REG_AW]});
        check("opcode_out", {25'd0, opcode_out}, {25'd0, last_out[OP_W-1:0]});
`ifdef PIPE_STAGE_FWD_EN
        check("fwd_valid", {31'd0, fwd_valid},
              {31'd0, (mq.size() > 0) && (last_out[OP_W +: REG_AW] != 0)});
        check("fwd_rd", {27'd0, fwd_rd}, {27'd0, last_out[OP_W +: REG_AW]});
        check("fwd_data", fwd_data, last_out[PW-1 -: XLEN]);
`endif
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);

        // Reset for two cycles, then a single pass-through beat.
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b1, mk(32'h1234, 32'hcafe, 5'd5, 7'h33), 1'b1);
        cycle();
        check("pt_result", result_out, 32'h1234);
        check("pt_rd", {27'd0, rd_out}, 32'd5);
        drive(1'b0, '0, 1'b1);
        cycle();

        // Back-pressure fill with A then B, then drain.
        drive(1'b1, mk(32'h11, 32'ha, 5'd1, 7'h03), 1'b0);
        cycle();
        drive(1'b1, mk(32'h22, 32'hb, 5'd2, 7'h23), 1'b0);
        cycle();
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_a", result_out, 32'h11);
        drive(1'b0, '0, 1'b1);
        cycle();
        check("bp_drain_b", result_out, 32'h22);
        cycle();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming 1..16 with no bubbles.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, mk(i, i * 3, i[4:0], 7'h13), 1'b1);
            cycle();
            check("stream", result_out, i);
        end
        drive(1'b0, '0, 1'b1);
        cycle();

        // Flush while FULL with C presented, then while ONE with in_ready high.
        drive(1'b1, mk(32'haa, 32'h1, 5'd3, 7'h03), 1'b0);
        cycle();
        drive(1'b1, mk(32'hbb, 32'h2, 5'd4, 7'h03), 1'b0);
        cycle();
        flush = 1'b1;
        drive(1'b1, mk(32'hcc, 32'h3, 5'd6, 7'h03), 1'b0);
        cycle();
        check("flush_full", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        drive(1'b1, mk(32'hdd, 32'h4, 5'd7, 7'h03), 1'b0);
        cycle();
        flush = 1'b1;
        drive(1'b1, mk(32'hee, 32'h5, 5'd8, 7'h03), 1'b1);
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        cycle();
        cycle();

        // Reset while FULL with out_ready high.
        drive(1'b1, mk(32'h77, 32'h7, 5'd9, 7'h33), 1'b0);
        cycle();
        drive(1'b1, mk(32'h88, 32'h8, 5'd10, 7'h33), 1'b0);
        cycle();
        rst = 1'b1;
        drive(1'b0, '0, 1'b1);
        cycle();
        check("rst_result", result_out, 32'd0);
        check("rst_data", data_out, 32'd0);
        rst = 1'b0;
        cycle();

        // Forwarding view: rd=0 is never forwarded.
        drive(1'b1, mk(32'h55, 32'h0, 5'd0, 7'h33), 1'b1);
        cycle();
        drive(1'b1, mk(32'h99, 32'h0, 5'd7, 7'h33), 1'b1);
        cycle();
        drive(1'b0, '0, 1'b1);
        cycle();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 3) != 0,
                  mk($urandom, $urandom, 5'($urandom), 7'($urandom)),
                  $urandom_range(0, 2) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
